userio_ps2host: RTL

USERIO_PS2HOST -- requirements
Module: userio_ps2host

---
 rtl/userio_ps2_pkg.sv | 7 +
 rtl/userio_ps2_fifo.sv | 41 ++++
 rtl/userio_ps2host.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/userio_ps2_pkg.sv
// userio_ps2_pkg: shared PS/2 host state encoding and protocol byte constants
package userio_ps2_pkg;
  typedef enum logic [2:0] {S_IDLE, S_RX, S_INHIBIT, S_REQ, S_TX, S_TX_ACK} state_t;
  localparam logic [7:0] PS2_ACK = 8'hFA;
  localparam logic [7:0] PS2_RESEND = 8'hFE;
  localparam logic [7:0] PS2_ERROR = 8'hFF;
endpackage

// File: rtl/userio_ps2_fifo.sv
// userio_ps2_fifo: register-based FIFO with combinational head and drop-on-full overflow pulse
module userio_ps2_fifo #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             valid,
  output logic [WIDTH-1:0] dout,
  output logic             overflow
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr, rd;
  logic [AW:0] count;
  logic full, do_push, do_pop;
  assign valid = count != '0;
  assign dout = mem[rd];
  always_comb begin
    full = count == (AW+1)'(DEPTH);
    do_pop = pop & valid;
    do_push = push & (~full | do_pop);
  end
  always_ff @(posedge clk) if (do_push) mem[wr] <= din;
  always_ff @(posedge clk) begin
    if (reset) begin
      wr <= '0;
      rd <= '0;
      count <= '0;
      overflow <= 1'b0;
    end else begin
      overflow <= push & full & ~do_pop;
      wr <= wr + AW'(do_push);
      rd <= rd + AW'(do_pop);
      count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end
endmodule

// File: rtl/userio_ps2host.sv
// userio_ps2host: PS/2 host controller with command transmit, resend retries and RX FIFO
module userio_ps2host
  import userio_ps2_pkg::*;
#(
  parameter int FIFO_DEPTH = 4,
  parameter int INHIBIT_CYC = 700,
  parameter int TIMEOUT_CYC = 14000,
  parameter int RETRIES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       clk_en,
  input  logic       ps2_clk_i,
  input  logic       ps2_dat_i,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  output logic       rx_valid,
  output logic [7:0] rx_data,
  input  logic       rx_ready,
  output logic       rx_overflow,
  output logic       frame_err,
  output logic       tx_fail
);
  localparam int TMAX = TIMEOUT_CYC > INHIBIT_CYC ? TIMEOUT_CYC : INHIBIT_CYC;
  localparam int TW = $clog2(TMAX + 1);
  localparam int RW = $clog2(RETRIES + 2);
  state_t state;
  logic [2:0] clk_h;
  logic [1:0] dat_h;
  logic [3:0] bit_cnt;
  logic [7:0] shift, cmd;
  logic [9:0] tx_frame;
  logic [RW-1:0] retry;
  logic [TW-1:0] timer;
  logic par, await_rsp, fall, dat, timed, rx_done, rx_ok, resend, push;
  assign cmd_ready = clk_en & (state == S_IDLE);
  always_comb begin
    fall = clk_h[2] & ~clk_h[1];
    dat = dat_h[1];
    timed = state == S_RX || state == S_REQ || state == S_TX || state == S_TX_ACK;
    rx_done = clk_en & fall & (state == S_RX) & (bit_cnt == 4'd9);
    rx_ok = (^{shift, par}) & dat;
    resend = await_rsp & (shift == PS2_RESEND);
    push = rx_done & rx_ok & ~(resend & (retry != '0));
    tx_frame = {1'b1, ~^cmd, cmd};
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      clk_h <= '1;
      dat_h <= '1;
      bit_cnt <= '0;
      shift <= '0;
      cmd <= '0;
      par <= 1'b0;
      await_rsp <= 1'b0;
      retry <= '0;
      timer <= '0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      frame_err <= 1'b0;
      tx_fail <= 1'b0;
    end else begin
      frame_err <= 1'b0;
      tx_fail <= 1'b0;
      if (clk_en) begin
        clk_h <= {clk_h[1:0], ps2_clk_i};
        dat_h <= {dat_h[0], ps2_dat_i};
        timer <= (state == S_INHIBIT || (timed && !fall)) ? timer + TW'(1) : '0;
        case (state)
          S_IDLE:
            if (cmd_valid) begin
              cmd <= cmd_data;
              retry <= RW'(RETRIES);
              await_rsp <= 1'b0;
              ps2_clk_oe <= 1'b1;
              timer <= '0;
              state <= S_INHIBIT;
            end else if (fall && !dat) begin
              bit_cnt <= '0;
              state <= S_RX;
            end
          S_RX:
            if (fall) begin
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt < 4'd8) shift <= {dat, shift[7:1]};
              if (bit_cnt == 4'd8) par <= dat;
              if (bit_cnt == 4'd9) begin
                state <= S_IDLE;
                await_rsp <= 1'b0;
                frame_err <= ~rx_ok;
                tx_fail <= rx_ok & resend & (retry == '0);
                if (rx_ok && resend && retry != '0) begin
                  retry <= retry - RW'(1);
                  ps2_clk_oe <= 1'b1;
                  timer <= '0;
                  state <= S_INHIBIT;
                end
              end
            end
          S_INHIBIT:
            if (timer == TW'(INHIBIT_CYC - 1)) begin
              ps2_clk_oe <= 1'b0;
              ps2_dat_oe <= 1'b1;
              timer <= '0;
              state <= S_REQ;
            end
          S_REQ:
            if (fall) begin
              ps2_dat_oe <= ~cmd[0];
              bit_cnt <= 4'd1;
              state <= S_TX;
            end
          S_TX:
            if (fall) begin
              ps2_dat_oe <= ~tx_frame[bit_cnt];
              bit_cnt <= bit_cnt + 4'd1;
              if (bit_cnt == 4'd9) state <= S_TX_ACK;
            end
          S_TX_ACK:
            if (fall) begin
              ps2_dat_oe <= 1'b0;
              frame_err <= dat;
              await_rsp <= ~dat;
              state <= S_IDLE;
            end
          default: state <= S_IDLE;
        endcase
        if (timed && !fall && timer == TW'(TIMEOUT_CYC - 1)) begin
          frame_err <= 1'b1;
          ps2_clk_oe <= 1'b0;
          ps2_dat_oe <= 1'b0;
          state <= S_IDLE;
        end
      end
    end
  end
  userio_ps2_fifo #(.DEPTH(FIFO_DEPTH), .WIDTH(8)) u_fifo (
    .clk(clk),
    .reset(reset),
    .push(push),
    .din(shift),
    .pop(rx_ready),
    .valid(rx_valid),
    .dout(rx_data),
    .overflow(rx_overflow)
  );
endmodule
